// File: rtl/otter_cu_fsm_if.sv
// Control-unit bus: decoder/datapath inputs to the multicycle FSM and its strobes back out.
// The master side is the FSM itself; the slave side is the surrounding core (or a bench).
interface otter_cu_fsm_if;
  logic [6:0] OPCODE;
  logic [2:0] FUNCT3;
  logic       INTR;
  logic       MIE;
  logic       MEM_RDY;

  logic       PC_WRITE;
  logic       PC_RST;
  logic       MEM_RDEN1;
  logic       MEM_RDEN2;
  logic       MEM_WE2;
  logic       REG_WRITE;
  logic       CSR_WE;
  logic       INT_TAKEN;
  logic       MEM_TIMEOUT;
  logic [2:0] STATE;

  modport master (
    input  OPCODE, FUNCT3, INTR, MIE, MEM_RDY,
    output PC_WRITE, PC_RST, MEM_RDEN1, MEM_RDEN2, MEM_WE2,
           REG_WRITE, CSR_WE, INT_TAKEN, MEM_TIMEOUT, STATE
  );

  modport slave (
    output OPCODE, FUNCT3, INTR, MIE, MEM_RDY,
    input  PC_WRITE, PC_RST, MEM_RDEN1, MEM_RDEN2, MEM_WE2,
           REG_WRITE, CSR_WE, INT_TAKEN, MEM_TIMEOUT, STATE
  );
endinterface

// File: rtl/otter_cu_fsm.sv
// Multicycle OTTER control FSM: fetch/execute sequencing, data-memory wait with timeout,
// and interrupt entry at instruction boundaries.
module otter_cu_fsm #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic          clk,
  input  logic          RST,
  otter_cu_fsm_if.master cu
);

  localparam int CW = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MEM_WAIT_MAX - 1);
  localparam logic [CW-1:0] WAIT_SAT  = CW'(MEM_WAIT_MAX);

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_EXEC      = 3'd2,
    ST_MEMWAIT   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_INTR      = 3'd5
  } state_t;

  typedef enum logic [2:0] {
    OPC_LOAD,
    OPC_STORE,
    OPC_BRANCH,
    OPC_ALU,
    OPC_CSR,
    OPC_MRET,
    OPC_NOP
  } op_class_t;

  state_t          state;
  state_t          next_state;
  op_class_t       op_class;
  logic [CW-1:0]   wait_cnt;
  logic            op_store;
  logic            mem_timeout;

  logic            pc_write;
  logic            pc_rst;
  logic            mem_rden1;
  logic            mem_rden2;
  logic            mem_we2;
  logic            reg_write;
  logic            csr_we;
  logic            int_taken;

  logic            irq_pending;
  logic            mem_enter;
  logic            enter_store;
  logic            cnt_inc;
  logic            timeout_hit;

  // Classify the current instruction once so the FSM only reasons about op kinds.
  always_comb begin
    op_class = OPC_NOP;
    case (cu.OPCODE)
      7'b0000011: op_class = OPC_LOAD;
      7'b0100011: op_class = OPC_STORE;
      7'b1100011: op_class = OPC_BRANCH;
      7'b0110011,
      7'b0010011,
      7'b0110111,
      7'b0010111,
      7'b1101111,
      7'b1100111: op_class = OPC_ALU;
      7'b1110011: op_class = (cu.FUNCT3 != 3'b000) ? OPC_CSR : OPC_MRET;
      default:    op_class = OPC_NOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      state       <= ST_INIT;
      wait_cnt    <= '0;
      op_store    <= 1'b0;
      mem_timeout <= 1'b0;
    end else begin
      state <= next_state;
      if (mem_enter) begin
        wait_cnt <= '0;
        op_store <= enter_store;
      end else if (cnt_inc && wait_cnt != WAIT_SAT) begin
        wait_cnt <= wait_cnt + CW'(1);
      end
      if (timeout_hit) begin
        mem_timeout <= 1'b1;
      end
    end
  end

  // Reset overrides the state decode so strobes are quiet in the very cycle RST rises.
  always_comb begin
    next_state  = state;
    pc_write    = 1'b0;
    pc_rst      = 1'b0;
    mem_rden1   = 1'b0;
    mem_rden2   = 1'b0;
    mem_we2     = 1'b0;
    reg_write   = 1'b0;
    csr_we      = 1'b0;
    int_taken   = 1'b0;
    mem_enter   = 1'b0;
    enter_store = 1'b0;
    cnt_inc     = 1'b0;
    timeout_hit = 1'b0;
    irq_pending = cu.INTR & cu.MIE;

    if (RST) begin
      pc_rst     = 1'b1;
      next_state = ST_INIT;
    end else begin
      case (state)
        ST_INIT: begin
          pc_rst     = 1'b1;
          next_state = ST_FETCH;
        end

        ST_FETCH: begin
          mem_rden1  = 1'b1;
          next_state = ST_EXEC;
        end

        ST_EXEC: begin
          next_state = irq_pending ? ST_INTR : ST_FETCH;
          case (op_class)
            OPC_LOAD: begin
              mem_rden2   = 1'b1;
              mem_enter   = 1'b1;
              next_state  = ST_MEMWAIT;
            end
            OPC_STORE: begin
              mem_we2     = 1'b1;
              mem_enter   = 1'b1;
              enter_store = 1'b1;
              next_state  = ST_MEMWAIT;
            end
            OPC_ALU: begin
              pc_write  = 1'b1;
              reg_write = 1'b1;
            end
            OPC_CSR: begin
              pc_write  = 1'b1;
              reg_write = 1'b1;
              csr_we    = 1'b1;
            end
            default: begin
              pc_write = 1'b1;
            end
          endcase
        end

        // MEM_RDY in the final allowed cycle still completes the access normally.
        ST_MEMWAIT: begin
          if (cu.MEM_RDY) begin
            if (op_store) begin
              mem_we2    = 1'b1;
              pc_write   = 1'b1;
              next_state = irq_pending ? ST_INTR : ST_FETCH;
            end else begin
              mem_rden2  = 1'b1;
              next_state = ST_WRITEBACK;
            end
          end else if (wait_cnt == WAIT_LAST) begin
            timeout_hit = 1'b1;
            pc_write    = 1'b1;
            next_state  = ST_FETCH;
          end else begin
            mem_rden2 = ~op_store;
            mem_we2   = op_store;
            cnt_inc   = 1'b1;
          end
        end

        ST_WRITEBACK: begin
          reg_write  = 1'b1;
          pc_write   = 1'b1;
          next_state = irq_pending ? ST_INTR : ST_FETCH;
        end

        ST_INTR: begin
          int_taken  = 1'b1;
          pc_write   = 1'b1;
          next_state = ST_FETCH;
        end

        default: begin
          next_state = ST_INIT;
        end
      endcase
    end
  end

  assign cu.PC_WRITE    = pc_write;
  assign cu.PC_RST      = pc_rst;
  assign cu.MEM_RDEN1   = mem_rden1;
  assign cu.MEM_RDEN2   = mem_rden2;
  assign cu.MEM_WE2     = mem_we2;
  assign cu.REG_WRITE   = reg_write;
  assign cu.CSR_WE      = csr_we;
  assign cu.INT_TAKEN   = int_taken;
  assign cu.MEM_TIMEOUT = mem_timeout;
  assign cu.STATE       = state;

endmodule
